// File: rtl/ara_w_signature.sv
// Observer on the VLSU AXI W channel: folds strobed bytes of accepted beats into a
// rotate-XOR signature and counts beats/bytes over the enabled region.
module ara_w_signature #(
  parameter int unsigned  AxiDataWidth = 128,
  localparam int unsigned StrbWidth    = AxiDataWidth / 8
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    en_i,
  input  logic [AxiDataWidth-1:0] w_data_i,
  input  logic [StrbWidth-1:0]    w_strb_i,
  input  logic                    w_valid_i,
  input  logic                    w_ready_i,
  output logic                    res_valid_o,
  input  logic                    res_ready_i,
  output logic [31:0]             res_sig_o,
  output logic [31:0]             res_bytes_o,
  output logic [31:0]             res_beats_o,
  output logic                    drop_o,
  output logic                    busy_o
);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StHold} state_e;

  state_e                  state_q, state_d;
  logic                    s1_valid_q, s1_valid_d;
  logic [AxiDataWidth-1:0] s1_data_q, s1_data_d;
  logic [StrbWidth-1:0]    s1_strb_q, s1_strb_d;
  logic [31:0]             sig_q, sig_d;
  logic [31:0]             bytes_q, bytes_d;
  logic [31:0]             beats_q, beats_d;
  logic                    drop_q, drop_d;

  logic        qual;
  logic [31:0] pop;
  logic [32:0] bytes_sum;
  logic [32:0] beats_sum;

  assign qual = w_valid_i & w_ready_i & en_i;

  always_comb begin
    state_d    = state_q;
    s1_valid_d = 1'b0;
    s1_data_d  = s1_data_q;
    s1_strb_d  = s1_strb_q;
    sig_d      = sig_q;
    bytes_d    = bytes_q;
    beats_d    = beats_q;
    drop_d     = drop_q;
    pop        = '0;
    for (int unsigned b = 0; b < StrbWidth; b++) begin
      pop = pop + 32'(s1_strb_q[b]);
    end
    bytes_sum = {1'b0, bytes_q} + {1'b0, pop};
    beats_sum = {1'b0, beats_q} + 33'd1;

    // Stage 2: fold the registered beat, bytes in ascending order.
    if (s1_valid_q) begin
      for (int unsigned b = 0; b < StrbWidth; b++) begin
        if (s1_strb_q[b]) begin
          sig_d = {sig_d[30:0], sig_d[31]} ^ {24'h0, s1_data_q[8*b +: 8]};
        end
      end
      bytes_d = bytes_sum[32] ? 32'hFFFF_FFFF : bytes_sum[31:0];
      beats_d = beats_sum[32] ? 32'hFFFF_FFFF : beats_sum[31:0];
    end

    case (state_q)
      StIdle: begin
        if (en_i) begin
          state_d = StRun;
          sig_d   = 32'hFFFF_FFFF;
          bytes_d = '0;
          beats_d = '0;
          drop_d  = 1'b0;
        end
      end
      StRun: begin
        if (qual) begin
          s1_valid_d = 1'b1;
          s1_strb_d  = w_strb_i;
          for (int unsigned b = 0; b < StrbWidth; b++) begin
            s1_data_d[8*b +: 8] = w_data_i[8*b +: 8] & {8{w_strb_i[b]}};
          end
        end
        if (!en_i) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        state_d = StHold;
        if (qual) begin
          drop_d = 1'b1;
        end
      end
      StHold: begin
        if (qual) begin
          drop_d = 1'b1;
        end
        if (res_ready_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_strb_q  <= '0;
      sig_q      <= 32'hFFFF_FFFF;
      bytes_q    <= '0;
      beats_q    <= '0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s1_strb_q  <= s1_strb_d;
      sig_q      <= sig_d;
      bytes_q    <= bytes_d;
      beats_q    <= beats_d;
      drop_q     <= drop_d;
    end
  end

  assign res_valid_o = (state_q == StHold);
  assign res_sig_o   = sig_q;
  assign res_bytes_o = bytes_q;
  assign res_beats_o = beats_q;
  assign drop_o      = drop_q;
  assign busy_o      = (state_q != StIdle);

endmodule

// File: doc/ara_w_signature.md
# ara_w_signature

Synthesizable observer on the Ara VLSU AXI write-data channel. It folds every strobed byte of each accepted W beat, inside the measured region, into a 32-bit rotate-XOR signature and counts beats and bytes. At the end of the region it presents the result through a valid/ready port. This lets on-chip self-check and FPGA runs compare stored results without a simulator-side byte dump. It sits in ara_soc beside i_system, snooping the VLSU W channel; its enable is hw_cnt_en_o[0].

## Interface
- AxiDataWidth, default 128: W data width (64 * NrLanes / 2).
- StrbWidth, default AxiDataWidth/8: derived; not overridable.
- clk_i  in  1  clock.
- rst_i  in  1  reset; synchronous, active-high.
- en_i  in  1  measured-region enable (hw counter enable).
- w_data_i  in  AxiDataWidth  snooped W data.
- w_strb_i  in  StrbWidth  snooped W strobe.
- w_valid_i  in  1  snooped W valid.
- w_ready_i  in  1  snooped W ready.
- res_valid_o  out  1  result available.
- res_ready_i  in  1  result consumed.
- res_sig_o  out  32  signature.
- res_bytes_o  out  32  strobed byte count, saturating.
- res_beats_o  out  32  accepted beat count, saturating.
- drop_o  out  1  sticky: a qualifying beat arrived while not in RUN.
- busy_o  out  1  state != IDLE.

## Operation
- Qualifying beat: w_valid_i && w_ready_i && en_i in the same cycle. The block never drives the channel.
- FSM states: IDLE, RUN, DRAIN, HOLD.
  - IDLE -> RUN when en_i = 1. On this transition: signature = 32'hFFFF_FFFF, byte and beat counts = 0, drop_o = 0. The beat in the transition cycle is not captured.
  - RUN -> DRAIN when en_i = 0.
  - DRAIN -> HOLD unconditionally.
  - HOLD -> IDLE when res_ready_i = 1. en_i is ignored in HOLD.
- Stage 1 (RUN only): on a qualifying beat, register data ANDed with the byte-expanded strobe, the strobe, and a valid bit. Otherwise clear the valid bit.
- Stage 2: when the stage-1 valid bit is set, process bytes b = 0 .. StrbWidth-1 in ascending order. For each byte with strb[b] = 1: sig = {sig[30:0], sig[31]} ^ {24'h0, byte_b}. Bytes with strb = 0 leave sig unchanged.
- Counters:
  - beats += 1 per stage-2 beat, including strb = 0 beats.
  - bytes += popcount(strb).
  - Both saturate at 32'hFFFF_FFFF and never wrap.
- drop_o: set when a qualifying beat occurs in IDLE (except the IDLE->RUN cycle), DRAIN or HOLD. Cleared only by reset or entry to RUN.
- res_* outputs always reflect the live registers. res_valid_o = (state == HOLD).

## Timing
- Reset values: res_valid_o 0, res_sig_o 32'hFFFF_FFFF, res_bytes_o 0, res_beats_o 0, drop_o 0, busy_o 0. State IDLE, stage-1 valid bit 0.
- Latency: a beat qualifying in cycle c updates the registers at the edge ending c+1, so it is visible on the outputs in c+2.
- End of region: if en_i falls in cycle t (state RUN), then DRAIN is in t+1 and HOLD (res_valid_o = 1) from t+2. A beat in t-1 is included; a beat in t is excluded.
- Handshake: res_valid_o stays high and res_* stay stable until res_ready_i = 1. A transfer occurs on the cycle where both are high; the next cycle is IDLE. res_ready_i is ignored outside HOLD.
- en_i = 1 in the cycle of the HOLD->IDLE handshake: the next cycle moves IDLE -> RUN as normal.
- Reset asserted in any state: the next cycle is IDLE with reset values, and any in-flight stage-1 beat is discarded.

## Test plan
- Single beat in RUN, strb = 0x0001, data byte0 = 0xAB -> after end of region: res_sig_o 32'hFFFF_FF54, res_bytes_o 1, res_beats_o 1, res_valid_o high 2 cycles after en_i falls.
- One beat with strb = 0x0003, bytes 0x01, 0x02 -> res_sig_o 32'hFFFF_FFFF, bytes 2, beats 1. Then a second beat with strb = 0x0000 -> sig unchanged, beats 2, bytes 2.
- Gating:
  - Beat with w_ready_i = 0 -> not counted.
  - Beat in the same cycle en_i falls -> not counted.
  - Beat in HOLD -> not counted, drop_o = 1.
  - Next IDLE->RUN -> drop_o = 0.
- Hold result with res_ready_i = 0 for 10 cycles while en_i toggles -> res_* stable, state stays HOLD. Raise res_ready_i with en_i = 1 -> IDLE for one cycle, then RUN with counts = 0 and sig = 32'hFFFF_FFFF.
- Full-strobe back-to-back stream of 1000 beats, AxiDataWidth = 128 -> bytes 16000, beats 1000, sig matching the reference model. Force bytes near 32'hFFFF_FFF8 -> saturates at 32'hFFFF_FFFF.
- Assert rst_i in RUN with a beat in stage 1 -> the next cycle shows all reset values, busy_o = 0, and no late update from the discarded beat.
